// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and width limit.
package serial_adder_pkg;

  // Largest operand width the serial adder is characterised for.
  localparam int unsigned SA_MAX_WIDTH = 32;

  // FSM encoding; the unused code 2'b11 recovers to S_IDLE on the next edge.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ADD  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/serial_adder_full_adder_bit.sv
// Full-adder bit slice built from two half-adder cells plus an OR.
//   half_add      : a, b -> sum = a^b, cout = a&b
//   full_adder_bit: a, b, cin -> sum = a^b^cin, cout = majority(a, b, cin)
// Purely combinational.

module half_add (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b;
  assign cout = a & b;

endmodule

module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic s0;
  logic c0;
  logic c1;

  half_add u_ha0 (
    .a    (a),
    .b    (b),
    .sum  (s0),
    .cout (c0)
  );

  half_add u_ha1 (
    .a    (s0),
    .b    (cin),
    .sum  (sum),
    .cout (c1)
  );

  // The two half-adder carries are never both set, so OR yields the majority.
  assign cout = c0 | c1;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, one result bit per clock, LSB first.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous reset, active-high
//   start : request, sampled only in IDLE; captures a, b, cin
//   a, b  : WIDTH-bit operands
//   cin   : carry-in
//   busy  : high while in ADD or DONE
//   done  : one-cycle pulse; sum/cout valid in that cycle
//   sum   : registered result, held until the next completion
//   cout  : registered carry-out, held until the next completion
// WIDTH legal range is 2..SA_MAX_WIDTH.

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_e           state;
  state_e           next_state;

  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  // Only the upper WIDTH-1 partial bits need storing; the new bit completes the word.
  logic [WIDTH-2:0] sh_s;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             s_c;
  logic             c_c;
  logic             last_bit_c;
  logic [WIDTH-1:0] sum_next_c;
  logic             busy_c;
  logic             done_c;

  full_adder_bit u_fab (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .cin  (carry),
    .sum  (s_c),
    .cout (c_c)
  );

  assign last_bit_c = (state == S_ADD) && (cnt == CW'(WIDTH - 1));
  assign sum_next_c = {s_c, sh_s};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_ADD;
      S_ADD:   if (last_bit_c) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state, so the registered flags track the state.
  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    case (next_state)
      S_ADD:  busy_c = 1'b1;
      S_DONE: begin
        busy_c = 1'b1;
        done_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Status output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_c;
      done <= done_c;
    end
  end

  // Operand/sum shift registers, carry flop, bit counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a  <= '0;
      sh_b  <= '0;
      sh_s  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sh_a  <= a;
            sh_b  <= b;
            carry <= cin;
            sh_s  <= '0;
            cnt   <= '0;
          end
        end
        S_ADD: begin
          sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
          sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
          sh_s  <= sum_next_c[WIDTH-1:1];
          carry <= c_c;
          if (last_bit_c) begin
            cnt  <= '0;
            sum  <= sum_next_c;
            cout <= c_c;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 and WIDTH=16.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [7:0]  sum;
  logic        cout;

  logic        start16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        cin16;
  logic        busy16;
  logic        done16;
  logic [15:0] sum16;
  logic        cout16;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst   (rst),
    .start (start16),
    .a     (a16),
    .b     (b16),
    .cin   (cin16),
    .busy  (busy16),
    .done  (done16),
    .sum   (sum16),
    .cout  (cout16)
  );

  // done must never stay high for two consecutive cycles.
  logic done_d1   = 1'b0;
  logic done16_d1 = 1'b0;
  always @(negedge clk) begin
    if (done === 1'b1) begin
      total++;
      if (done_d1 === 1'b1) begin
        bad++;
        $display("FAIL done_width8: high two cycles in a row at cycle %0d", cyc);
      end
    end
    if (done16 === 1'b1) begin
      total++;
      if (done16_d1 === 1'b1) begin
        bad++;
        $display("FAIL done_width16: high two cycles in a row at cycle %0d", cyc);
      end
    end
    done_d1   <= done;
    done16_d1 <= done16;
  end

  // Present one request for a single edge; caller is #1 after an edge with the DUT idle.
  task automatic kick8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    a = av; b = bv; cin = cv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic kick16(input logic [15:0] av, input logic [15:0] bv, input logic cv);
    a16 = av; b16 = bv; cin16 = cv; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
  endtask

  // Edges counted after the accepting edge until done is seen (bounded).
  task automatic wait_done8(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic wait_done16(output int n);
    n = 0;
    while (done16 !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (sum !== 8'h00) begin bad++; $display("FAIL reset_sum: got %h want 00", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout: got %b want 0", cout); end
    total++; if (busy16 !== 1'b0 || sum16 !== 16'h0000) begin
      bad++; $display("FAIL reset_w16: got busy=%b sum=%h want 0/0000", busy16, sum16);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [7:0] va [6] = '{8'h05, 8'hFF, 8'hFF, 8'h12, 8'h80, 8'hC3};
    logic [7:0] vb [6] = '{8'h03, 8'h01, 8'hFF, 8'h34, 8'h80, 8'h5A};
    logic       vc [6] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
    logic [7:0] es [6] = '{8'h08, 8'h00, 8'hFF, 8'h47, 8'h00, 8'h1E};
    logic       ec [6] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1};
    int n;
    for (int i = 0; i < 6; i++) begin
      kick8(va[i], vb[i], vc[i]);
      if (i == 0) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy); end
      end
      wait_done8(n);
      total++; if (n != 8) begin bad++; $display("FAIL basic_latency[%0d]: got %0d want 8", i, n); end
      total++; if (sum !== es[i]) begin bad++; $display("FAIL basic_sum[%0d]: got %h want %h", i, sum, es[i]); end
      total++; if (cout !== ec[i]) begin bad++; $display("FAIL basic_cout[%0d]: got %b want %b", i, cout, ec[i]); end
      @(posedge clk); #1;
    end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL basic_idle: got busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  task automatic test_hold_start;
    int pulses;
    logic [7:0] got_s;
    logic       got_c;
    pulses = 0; got_s = 8'h00; got_c = 1'b0;
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    repeat (2) begin @(posedge clk); #1; end
    a = 8'hAA; b = 8'hAA; cin = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1) begin
        pulses++;
        got_s = sum;
        got_c = cout;
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    total++; if (pulses != 1) begin bad++; $display("FAIL hold_pulses: got %0d want 1", pulses); end
    total++; if (got_s !== 8'h10) begin bad++; $display("FAIL hold_sum: got %h want 10", got_s); end
    total++; if (got_c !== 1'b0) begin bad++; $display("FAIL hold_cout: got %b want 0", got_c); end
    total++; if (sum !== 8'h10) begin bad++; $display("FAIL hold_sum_kept: got %h want 10", sum); end
  endtask

  task automatic test_reset_mid;
    int n;
    int pulses;
    kick8(8'h77, 8'h11, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done: got %b want 0", done); end
    total++; if (sum !== 8'h00) begin bad++; $display("FAIL rstmid_sum: got %h want 00", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL rstmid_cout: got %b want 0", cout); end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL rstmid_no_done: got %0d want 0", pulses); end
    kick8(8'h10, 8'h20, 1'b0);
    wait_done8(n);
    total++; if (n != 8 || sum !== 8'h30 || cout !== 1'b0) begin
      bad++; $display("FAIL rstmid_after: got n=%0d sum=%h cout=%b want 8/30/0", n, sum, cout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int n;
    int t1;
    int t2;
    kick8(8'h01, 8'h02, 1'b0);
    wait_done8(n);
    t1 = cyc;
    total++; if (n != 8 || sum !== 8'h03) begin
      bad++; $display("FAIL b2b_first: got n=%0d sum=%h want 8/03", n, sum);
    end
    @(posedge clk); #1;
    kick8(8'h40, 8'h41, 1'b0);
    wait_done8(n);
    t2 = cyc;
    total++; if (t2 - t1 != 10) begin bad++; $display("FAIL b2b_spacing: got %0d want 10", t2 - t1); end
    total++; if (sum !== 8'h81 || cout !== 1'b0) begin
      bad++; $display("FAIL b2b_second: got sum=%h cout=%b want 81/0", sum, cout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random8;
    int n;
    int errs;
    logic [7:0] av;
    logic [7:0] bv;
    logic       cv;
    logic [8:0] exp;
    errs = 0;
    for (int i = 0; i < 200; i++) begin
      av = 8'($urandom); bv = 8'($urandom); cv = 1'($urandom);
      exp = 9'(av) + 9'(bv) + 9'(cv);
      kick8(av, bv, cv);
      wait_done8(n);
      total++;
      if (n != 8 || {cout, sum} !== exp) begin
        bad++;
        if (errs < 5) $display("FAIL rand8[%0d]: got n=%0d {cout,sum}=%h want 8/%h", i, n, {cout, sum}, exp);
        errs++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_width16;
    logic [15:0] va [4] = '{16'hFFFF, 16'h1234, 16'h8000, 16'hABCD};
    logic [15:0] vb [4] = '{16'h0001, 16'h4321, 16'h8000, 16'h1111};
    logic        vc [4] = '{1'b0,     1'b0,     1'b1,     1'b0};
    logic [16:0] ex [4] = '{17'h10000, 17'h05555, 17'h10001, 17'h0BCDE};
    int n;
    int errs;
    logic [15:0] av;
    logic [15:0] bv;
    logic        cv;
    logic [16:0] exp;
    for (int i = 0; i < 4; i++) begin
      kick16(va[i], vb[i], vc[i]);
      wait_done16(n);
      total++; if (n != 16) begin bad++; $display("FAIL w16_latency[%0d]: got %0d want 16", i, n); end
      total++; if ({cout16, sum16} !== ex[i]) begin
        bad++; $display("FAIL w16_result[%0d]: got %h want %h", i, {cout16, sum16}, ex[i]);
      end
      @(posedge clk); #1;
    end
    errs = 0;
    for (int i = 0; i < 100; i++) begin
      av = 16'($urandom); bv = 16'($urandom); cv = 1'($urandom);
      exp = 17'(av) + 17'(bv) + 17'(cv);
      kick16(av, bv, cv);
      wait_done16(n);
      total++;
      if (n != 16 || {cout16, sum16} !== exp) begin
        bad++;
        if (errs < 5) $display("FAIL rand16[%0d]: got n=%0d {cout,sum}=%h want 16/%h", i, n, {cout16, sum16}, exp);
        errs++;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_start();
    test_reset_mid();
    test_back_to_back();
    test_random8();
    test_width16();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
